// File: rtl/contador_modn.sv
// contador_modn: modulo-N up/down counter with synchronous load, wrap or
// one-shot operation, cascade terminal count, zero flag and a one-cycle
// out-of-range load indication. Asynchronous active-low clear.
module contador_modn #(
  parameter int WIDTH   = 4,  // counter register width in bits
  parameter int MODULUS = 6   // count range is 0 .. MODULUS-1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] data,
  input  logic             loadn,
  input  logic             en,
  input  logic             dir,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             done,
  output logic             load_err
);

  // Reject parameter sets where the range cannot be held in the register
  // or where there is nothing to count.
  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
      $error("contador_modn: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  // Highest legal count, also the up-count terminal value.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // MODULUS widened by one bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             load_err_reg, load_err_next;

  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic             load_in_range;

  // Terminal value follows dir in the same cycle: 0 going down, MAX going up.
  assign term_val      = dir ? MAX_VAL : '0;
  assign at_term       = (count_reg == term_val);
  assign load_in_range = ({1'b0, data} < MOD_EXT);

  // State, count and error pulse registers; clrn clears them without a clock.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg    <= RUN;
      count_reg    <= '0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      load_err_reg <= load_err_next;
    end
  end

  // Next-state logic: load beats count, count beats hold; DONE only leaves on load.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    load_err_next = 1'b0;

    if (!loadn) begin
      // Out-of-range data is clamped to the top of the range and flagged.
      count_next    = load_in_range ? data : MAX_VAL;
      load_err_next = ~load_in_range;
      state_next    = RUN;
    end else if (en && (state_reg == RUN)) begin
      if (!at_term) begin
        count_next = dir ? (count_reg + WIDTH'(1)) : (count_reg - WIDTH'(1));
      end else if (!oneshot) begin
        // Explicit wrap so a non-power-of-two modulus never overflows naturally.
        count_next = dir ? '0 : MAX_VAL;
      end else begin
        // One-shot expiry: count stays on the terminal value.
        state_next = DONE;
      end
    end
  end

  assign count    = count_reg;
  assign done     = (state_reg == DONE);
  assign load_err = load_err_reg;
  // Cascade enable: only while running, so an expired one-shot stops the chain.
  assign tc       = en & at_term & ~done;
  assign zero     = (count_reg == '0);

endmodule
